// File: rtl/entrada_buffer.sv
// entrada_buffer: input staging buffer with run-time LIFO/FIFO order, status, sticky errors.
// Optional head-peek port enabled by defining ENTRADA_BUFFER_PEEK_EN.
module entrada_buffer #(
    parameter int DATA_W = 16,
    parameter int OUT_W  = 32,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              push,
    input  logic              pop,
    input  logic              clear,
    input  logic              mode_fifo,
    output logic [OUT_W-1:0]  data_out,
    output logic              out_valid,
    output logic              empty,
    output logic              full,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              underflow,
    output logic              mode_q
`ifdef ENTRADA_BUFFER_PEEK_EN
    ,
    output logic [OUT_W-1:0]  peek_data
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    function automatic logic [OUT_W-1:0] zext(input logic [DATA_W-1:0] d);
        zext = OUT_W'(d);
    endfunction

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [OUT_W-1:0]  data_out_r;
    logic              out_valid_r, empty_r, full_r, overflow_r, underflow_r, mode_r;

    logic [AW-1:0]     wr_nxt_s, rd_nxt_s, head_idx_s, top_idx_s, mem_addr_s;
    logic [CNT_W-1:0]  cnt_nxt_s;
    logic [OUT_W-1:0]  dout_nxt_s;
    logic              valid_nxt_s, of_nxt_s, uf_nxt_s, mode_nxt_s, mem_we_s;
    logic [DATA_W-1:0] head_s;

    // LIFO head is the slot just below wr_ptr; FIFO head is the oldest entry at rd_ptr.
    assign top_idx_s  = wr_ptr_r - AW'(1);
    assign head_idx_s = mode_r ? rd_ptr_r : top_idx_s;
    assign head_s     = mem_r[head_idx_s];

    // Next-state decode: clear dominates, then the push/pop combination.
    always_comb begin
        wr_nxt_s    = wr_ptr_r;
        rd_nxt_s    = rd_ptr_r;
        cnt_nxt_s   = count_r;
        dout_nxt_s  = data_out_r;
        valid_nxt_s = 1'b0;
        of_nxt_s    = overflow_r;
        uf_nxt_s    = underflow_r;
        mode_nxt_s  = mode_r;
        mem_we_s    = 1'b0;
        mem_addr_s  = wr_ptr_r;
        if (clear) begin
            wr_nxt_s   = {AW{1'b0}};
            rd_nxt_s   = {AW{1'b0}};
            cnt_nxt_s  = {CNT_W{1'b0}};
            dout_nxt_s = {OUT_W{1'b0}};
            of_nxt_s   = 1'b0;
            uf_nxt_s   = 1'b0;
            mode_nxt_s = mode_fifo;
        end else begin
            if (empty_r && !push) begin
                mode_nxt_s = mode_fifo;
            end else begin
                mode_nxt_s = mode_r;
            end
            case ({push, pop})
                2'b11: begin
                    if (!empty_r) begin
                        dout_nxt_s  = zext(head_s);
                        valid_nxt_s = 1'b1;
                        mem_we_s    = 1'b1;
                        if (mode_r) begin
                            mem_addr_s = wr_ptr_r;
                            wr_nxt_s   = wr_ptr_r + AW'(1);
                            rd_nxt_s   = rd_ptr_r + AW'(1);
                        end else begin
                            mem_addr_s = top_idx_s;
                        end
                    end else begin
                        // Empty: the push lands, the pop is the error.
                        mem_we_s  = 1'b1;
                        wr_nxt_s  = wr_ptr_r + AW'(1);
                        cnt_nxt_s = count_r + CNT_W'(1);
                        uf_nxt_s  = 1'b1;
                    end
                end
                2'b10: begin
                    if (!full_r) begin
                        mem_we_s  = 1'b1;
                        wr_nxt_s  = wr_ptr_r + AW'(1);
                        cnt_nxt_s = count_r + CNT_W'(1);
                    end else begin
                        of_nxt_s = 1'b1;
                    end
                end
                2'b01: begin
                    if (!empty_r) begin
                        dout_nxt_s  = zext(head_s);
                        valid_nxt_s = 1'b1;
                        cnt_nxt_s   = count_r - CNT_W'(1);
                        if (mode_r) begin
                            rd_nxt_s = rd_ptr_r + AW'(1);
                        end else begin
                            wr_nxt_s = top_idx_s;
                        end
                    end else begin
                        uf_nxt_s = 1'b1;
                    end
                end
                default: begin
                    valid_nxt_s = 1'b0;
                end
            endcase
        end
    end

    // Control and status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            data_out_r  <= {OUT_W{1'b0}};
            out_valid_r <= 1'b0;
            empty_r     <= 1'b1;
            full_r      <= 1'b0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
            mode_r      <= 1'b0;
        end else begin
            wr_ptr_r    <= wr_nxt_s;
            rd_ptr_r    <= rd_nxt_s;
            count_r     <= cnt_nxt_s;
            data_out_r  <= dout_nxt_s;
            out_valid_r <= valid_nxt_s;
            empty_r     <= (cnt_nxt_s == {CNT_W{1'b0}});
            full_r      <= (cnt_nxt_s == DEPTH_C);
            overflow_r  <= of_nxt_s;
            underflow_r <= uf_nxt_s;
            mode_r      <= mode_nxt_s;
        end
    end

    // Storage array; contents are not reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_addr_s] <= data_in;
        end
    end

    assign data_out  = data_out_r;
    assign out_valid = out_valid_r;
    assign empty     = empty_r;
    assign full      = full_r;
    assign count     = count_r;
    assign overflow  = overflow_r;
    assign underflow = underflow_r;
    assign mode_q    = mode_r;

`ifdef ENTRADA_BUFFER_PEEK_EN
    assign peek_data = empty_r ? {OUT_W{1'b0}} : zext(head_s);
`endif

endmodule

// File: tb/tb_entrada_buffer.sv
// Scoreboard bench for entrada_buffer: queue model of contents, expected pops queued and compared.
module tb_entrada_buffer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] data_in = 16'h0;
    logic        push = 1'b0, pop = 1'b0, clear = 1'b0, mode_fifo = 1'b0;
    logic [31:0] data_out;
    logic        out_valid, empty, full, overflow, underflow, mode_q;
    logic [4:0]  count;
`ifdef ENTRADA_BUFFER_PEEK_EN
    logic [31:0] peek_data;
`endif

    entrada_buffer dut (
        .clk(clk), .reset(reset), .data_in(data_in), .push(push), .pop(pop),
        .clear(clear), .mode_fifo(mode_fifo), .data_out(data_out),
        .out_valid(out_valid), .empty(empty), .full(full), .count(count),
        .overflow(overflow), .underflow(underflow), .mode_q(mode_q)
`ifdef ENTRADA_BUFFER_PEEK_EN
        , .peek_data(peek_data)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [15:0] model[$];
    logic [31:0] exp_q[$];
    logic        m_mode = 1'b0, m_of = 1'b0, m_uf = 1'b0;
    logic [31:0] m_dout = 32'h0;

    task automatic model_reset(input logic md);
        model.delete();
        exp_q.delete();
        m_mode = md;
        m_of   = 1'b0;
        m_uf   = 1'b0;
        m_dout = 32'h0;
    endtask

    // One clock of push/pop stimulus with full output comparison afterwards.
    task automatic step(input logic p, input logic q, input logic [15:0] d);
        logic        exp_valid;
        logic [31:0] got_exp;
        logic [31:0] exp_peek;
        int          sz;
        exp_valid = 1'b0;
        sz = model.size();
        if (p && q && sz > 0) begin
            exp_valid = 1'b1;
            if (m_mode) begin
                exp_q.push_back({16'h0, model[0]});
                void'(model.pop_front());
                model.push_back(d);
            end else begin
                exp_q.push_back({16'h0, model[sz-1]});
                model[sz-1] = d;
            end
        end else if (p && q) begin
            model.push_back(d);
            m_uf = 1'b1;
        end else if (p) begin
            if (sz < 16) model.push_back(d);
            else m_of = 1'b1;
        end else if (q) begin
            if (sz > 0) begin
                exp_valid = 1'b1;
                if (m_mode) begin
                    exp_q.push_back({16'h0, model[0]});
                    void'(model.pop_front());
                end else begin
                    exp_q.push_back({16'h0, model[sz-1]});
                    void'(model.pop_back());
                end
            end else begin
                m_uf = 1'b1;
            end
        end
        if (sz == 0 && !p) m_mode = mode_fifo;

        push = p; pop = q; data_in = d;
        @(posedge clk); #1;
        push = 1'b0; pop = 1'b0;

        checks++;
        if (out_valid !== exp_valid) begin
            failures++; $display("FAIL out_valid: got %b want %b", out_valid, exp_valid);
        end
        if (out_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++; $display("FAIL scoreboard: unexpected output %h, want none", data_out);
            end else begin
                got_exp = exp_q.pop_front();
                m_dout = got_exp;
                if (data_out !== got_exp) begin
                    failures++; $display("FAIL pop_data: got %h want %h", data_out, got_exp);
                end
            end
        end else if (exp_valid) begin
            void'(exp_q.pop_front());
        end
        checks++;
        if (data_out !== m_dout) begin
            failures++; $display("FAIL data_out_hold: got %h want %h", data_out, m_dout);
        end
        checks++;
        if (count !== 5'(model.size())) begin
            failures++; $display("FAIL count: got %0d want %0d", count, model.size());
        end
        checks++;
        if (empty !== (model.size() == 0) || full !== (model.size() == 16)) begin
            failures++; $display("FAIL empty_full: got %b%b want %b%b", empty, full,
                                 model.size() == 0, model.size() == 16);
        end
        checks++;
        if (overflow !== m_of || underflow !== m_uf) begin
            failures++; $display("FAIL flags: got of=%b uf=%b want of=%b uf=%b",
                                 overflow, underflow, m_of, m_uf);
        end
        checks++;
        if (mode_q !== m_mode) begin
            failures++; $display("FAIL mode_q: got %b want %b", mode_q, m_mode);
        end
        exp_peek = 32'h0;
        if (model.size() > 0) exp_peek = m_mode ? {16'h0, model[0]} : {16'h0, model[model.size()-1]};
`ifdef ENTRADA_BUFFER_PEEK_EN
        checks++;
        if (peek_data !== exp_peek) begin
            failures++; $display("FAIL peek_data: got %h want %h", peek_data, exp_peek);
        end
`endif
    endtask

    task automatic do_clear(input logic md);
        mode_fifo = md;
        clear = 1'b1; push = 1'b1; pop = 1'b1; data_in = 16'hDEAD;
        @(posedge clk); #1;
        clear = 1'b0; push = 1'b0; pop = 1'b0;
        model_reset(md);
        checks++;
        if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || data_out !== 32'h0 ||
            out_valid !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0 || mode_q !== md) begin
            failures++;
            $display("FAIL clear: got cnt=%0d e=%b f=%b d=%h v=%b of=%b uf=%b m=%b want 0 1 0 0 0 0 0 %b",
                     count, empty, full, data_out, out_valid, overflow, underflow, mode_q, md);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        checks++;
        if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || data_out !== 32'h0 ||
            out_valid !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0 || mode_q !== 1'b0) begin
            failures++;
            $display("FAIL reset: got cnt=%0d e=%b f=%b d=%h v=%b of=%b uf=%b m=%b want 0 1 0 0 0 0 0 0",
                     count, empty, full, data_out, out_valid, overflow, underflow, mode_q);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset(1'b0);
        @(posedge clk); #1;
    endtask

    task automatic test_lifo();
        mode_fifo = 1'b0;
        step(1'b1, 1'b0, 16'h0001);
        step(1'b1, 1'b0, 16'h0002);
        step(1'b1, 1'b0, 16'h0003);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'h0);
        checks++;
        if (data_out !== 32'h00000001 || empty !== 1'b1) begin
            failures++; $display("FAIL lifo_last: got %h e=%b want 00000001 e=1", data_out, empty);
        end
    endtask

    task automatic test_fifo();
        do_clear(1'b1);
        step(1'b1, 1'b0, 16'h000A);
        mode_fifo = 1'b0;
        step(1'b1, 1'b0, 16'h000B);
        step(1'b1, 1'b0, 16'h000C);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'h0);
        checks++;
        if (data_out !== 32'h0000000C || mode_q !== 1'b1) begin
            failures++; $display("FAIL fifo_last: got %h m=%b want 0000000c m=1", data_out, mode_q);
        end
        step(1'b0, 1'b0, 16'h0);
    endtask

    task automatic test_full(input logic md);
        do_clear(md);
        for (int i = 1; i <= 17; i++) step(1'b1, 1'b0, 16'(i));
        checks++;
        if (count !== 5'd16 || full !== 1'b1 || overflow !== 1'b1) begin
            failures++; $display("FAIL full_state: got cnt=%0d f=%b of=%b want 16 1 1", count, full, overflow);
        end
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 16'h0);
        checks++;
        if (data_out !== (md ? 32'd16 : 32'd1)) begin
            failures++; $display("FAIL full_lastpop: got %h want %h", data_out, md ? 32'd16 : 32'd1);
        end
    endtask

    task automatic test_underflow();
        do_clear(1'b0);
        step(1'b1, 1'b0, 16'h0042);
        step(1'b0, 1'b1, 16'h0);
        step(1'b0, 1'b1, 16'h0);
        step(1'b1, 1'b1, 16'h0077);
        checks++;
        if (count !== 5'd1 || underflow !== 1'b1 || data_out !== 32'h42) begin
            failures++; $display("FAIL uf_pushpop: got cnt=%0d uf=%b d=%h want 1 1 00000042",
                                 count, underflow, data_out);
        end
        do_clear(1'b0);
    endtask

    task automatic test_back_to_back(input logic md);
        do_clear(md);
        step(1'b1, 1'b0, 16'h0005);
        step(1'b1, 1'b0, 16'h0006);
        step(1'b1, 1'b1, 16'h0007);
        checks++;
        if (data_out !== (md ? 32'h5 : 32'h6) || count !== 5'd2) begin
            failures++; $display("FAIL b2b: got %h cnt=%0d want %h cnt=2", data_out, count, md ? 32'h5 : 32'h6);
        end
        step(1'b0, 1'b1, 16'h0);
        step(1'b0, 1'b1, 16'h0);
    endtask

    task automatic test_async_reset();
        do_clear(1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'h0100 + 16'(i));
        step(1'b1, 1'b1, 16'h0200);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || data_out !== 32'h0 ||
            out_valid !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0 || mode_q !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: got cnt=%0d e=%b d=%h v=%b m=%b want 0 1 0 0 0",
                     count, empty, data_out, out_valid, mode_q);
        end
`ifdef ENTRADA_BUFFER_PEEK_EN
        checks++;
        if (peek_data !== 32'h0) begin
            failures++; $display("FAIL async_peek: got %h want 0", peek_data);
        end
`endif
        @(negedge clk);
        reset = 1'b0;
        mode_fifo = 1'b0;
        model_reset(1'b0);
        step(1'b0, 1'b0, 16'h0);
    endtask

    initial begin
        test_reset();
        test_lifo();
        test_fifo();
        test_full(1'b1);
        test_full(1'b0);
        test_underflow();
        test_back_to_back(1'b0);
        test_back_to_back(1'b1);
        test_async_reset();
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/entrada_buffer.md
Name: entrada_buffer

Overview:
- Parametrised input staging buffer for the datapath's input front end. It captures DATA_W-bit words from the input switches/bus on push and returns them on pop, zero-extended to OUT_W.
- Storage order is selectable at run time: LIFO (stack, legacy behaviour) or FIFO (queue).
- Adds full/empty/count status, sticky overflow/underflow error flags, a defined rule for simultaneous push+pop, and a registered output-valid strobe.

Parameters:
- DATA_W, 16, width of input word.
- OUT_W, 32, width of output word; must be >= DATA_W; upper bits are zero-filled.
- DEPTH, 16, number of entries; power of 2, >= 2.
- CNT_W, $clog2(DEPTH+1), width of the count output (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- data_in  in  DATA_W  word to store.
- push  in  1  store data_in this cycle.
- pop  in  1  retrieve head word this cycle.
- clear  in  1  synchronous flush: empties the buffer and clears the error flags.
- mode_fifo  in  1  requested order: 0 = LIFO, 1 = FIFO.
- data_out  out  OUT_W  last popped word, zero-extended.
- out_valid  out  1  one-cycle strobe; data_out updated this cycle.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- count  out  CNT_W  number of stored entries.
- overflow  out  1  sticky: a push was rejected.
- underflow  out  1  sticky: a pop was rejected.
- mode_q  out  1  active order currently in use.

Behaviour:
- Reset (async, active-high): all pointers 0; count 0; empty=1; full=0; data_out=0; out_valid=0; overflow=0; underflow=0; mode_q=0 (LIFO). Memory contents are don't-care.
- All other state updates on the rising edge of clk.
- Priority: clear > push/pop.
  - clear=1: pointers reset, count=0, data_out=0, out_valid=0, flags cleared, mode_q reloaded from mode_fifo. push and pop are ignored that cycle.
- Mode latch: mode_q <= mode_fifo only on a cycle where count==0 and push==0, or on clear. Requests made while the buffer is non-empty are ignored.
- Head entry:
  - LIFO: the most recent entry (top, at wr_ptr-1).
  - FIFO: the oldest entry (at rd_ptr).
  - Pointers wrap modulo DEPTH.
- Push only:
  - If not full: write data_in at wr_ptr, wr_ptr+1, count+1.
  - If full: write dropped, overflow<=1, state unchanged.
- Pop only:
  - If not empty: data_out <= head zero-extended, out_valid<=1 next cycle (1-cycle latency); count-1.
  - LIFO pop decrements wr_ptr; FIFO pop increments rd_ptr.
  - If empty: underflow<=1, data_out holds, out_valid=0.
- Push+pop, not empty (including full): data_out <= old head, out_valid=1, count unchanged, no flags.
  - LIFO: the top slot is overwritten with data_in.
  - FIFO: write at wr_ptr, read at rd_ptr, both pointers advance.
- Push+pop, empty: push performed (count becomes 1), pop rejected, underflow<=1.
- Idle cycles: data_out holds its last value; out_valid=0.
- Status outputs (empty, full, count) are registered and reflect state after the edge.
- Sticky flags clear only on reset or clear.

Optional Feature:
- Macro: ENTRADA_BUFFER_PEEK_EN.
- Defined: adds output port peek_data [OUT_W], giving the current head word zero-extended, combinational from storage; 0 when empty. peek_data does not affect pointers or flags.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then LIFO push 0x0001, 0x0002, 0x0003, then pop x3 -> data_out 0x00000003, 0x00000002, 0x00000001 on consecutive cycles with out_valid=1 each; empty=1 at end.
- clear with mode_fifo=1, push 0xA, 0xB, 0xC, then pop x3 -> data_out 0xA, 0xB, 0xC; mode_q=1. Toggling mode_fifo to 0 mid-sequence has no effect until empty.
- Push 17 words with DEPTH=16 -> full=1 after the 16th, overflow=1 after the 17th, count=16. Then pop x16 returns words 1..16 (FIFO) or 16..1 (LIFO); the 17th word never appears.
- Pop on empty -> underflow=1, out_valid=0, data_out unchanged. Push+pop on empty -> count=1, underflow=1. clear -> flags 0, count 0, data_out 0.
- LIFO holding 0x5,0x6, push 0x7 with pop -> data_out=0x6, count stays 2, next pop returns 0x7. FIFO holding 0x5,0x6, push 0x7 with pop -> data_out=0x5, then pops return 0x6, 0x7.
- Assert reset asynchronously mid-burst (between edges) with count=5 -> all outputs at reset values immediately, before the next clk edge. With ENTRADA_BUFFER_PEEK_EN defined, peek_data tracks the head through all of the above and reads 0 when empty.
